// File: rtl/mem_pkg.sv
// Shared definitions for the CPU memory command bus and the responder FSM.
package mem_pkg;

  // mem_cmd encodings, shared with the CPU controller; 2'b11 is illegal
  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Default memory-mapped I/O locations (both lie above the RAM)
  localparam logic [8:0] LED_ADDR_DEF = 9'h100;
  localparam logic [8:0] SW_ADDR_DEF  = 9'h140;

endpackage

// File: rtl/mem_responder_ram_array.sv
// Single-port word RAM: synchronous write, combinational read, no reset.
module ram_array #(
  parameter int DEPTH = 256,
  parameter int DW    = 16,
  parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [IW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Store the word when enabled; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory responder for the CPU mem_cmd bus: one access at a time with
// WAIT_CYCLES wait states, a one-cycle mem_ready pulse, and an internal RAM.
// Define MEM_MMIO_EN to map the LED register and switch inputs into the
// address space; without it led reads as 0 and sw is ignored.
module mem_responder import mem_pkg::*; #(
  parameter int             AW          = 9,
  parameter int             DW          = 16,
  parameter int             DEPTH       = 256,
  parameter int             WAIT_CYCLES = 1,
  parameter logic [AW-1:0]  LED_ADDR    = AW'(LED_ADDR_DEF),
  parameter logic [AW-1:0]  SW_ADDR     = AW'(SW_ADDR_DEF)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    mem_cmd,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] write_data,
  output logic [DW-1:0] read_data,
  output logic          mem_ready,
  output logic          busy,
  input  logic [7:0]    sw,
  output logic [7:0]    led
);

  localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [7:0]    led_q, led_d;

  logic [AW-1:0] acc_addr;
  logic [1:0]    acc_cmd;
  logic          in_range;
  logic          is_led;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] rd_val;

  // While idle the live bus feeds the RAM port so zero-wait reads see the
  // addressed word on the accept edge; afterwards only latched values count.
  assign acc_addr = (state_q == IDLE) ? mem_addr : addr_q;
  assign acc_cmd  = (state_q == IDLE) ? mem_cmd  : cmd_q;
  assign in_range = {1'b0, acc_addr} < DEPTH_L;

`ifdef MEM_MMIO_EN
  assign is_led = (addr_q == LED_ADDR);
`else
  logic unused_sw;
  assign unused_sw = ^sw;
  assign is_led    = 1'b0;
`endif

  // The write lands on the edge leaving DONE; a reset on that edge cancels it
  assign ram_we = (state_q == DONE) && (cmd_q == MWRITE) && in_range && !is_led && !reset;

  ram_array #(.DEPTH(DEPTH), .DW(DW), .IW(IW)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (acc_addr[IW-1:0]),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  // Read decode: switches win over RAM, anything unmapped reads as zero
  always_comb begin
    rd_val = '0;
`ifdef MEM_MMIO_EN
    if (acc_addr == SW_ADDR) rd_val = {{(DW-8){1'b0}}, sw};
    else
`endif
    if (in_range) rd_val = ram_rdata;
  end

  // Next-state logic: accept in IDLE, count down in WAIT, complete in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    led_d   = led_q;
    case (state_q)
      IDLE: begin
        if (mem_cmd == MREAD || mem_cmd == MWRITE) begin
          cmd_d   = mem_cmd;
          addr_d  = mem_addr;
          wdata_d = write_data;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        if (cmd_q == MWRITE && is_led) led_d = wdata_q[7:0];
      end
      default: state_d = IDLE;
    endcase
    // Read data is captured on the edge entering DONE so it is valid with mem_ready
    if (state_d == DONE && acc_cmd == MREAD) rdata_d = rd_val;
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= MNONE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      led_q   <= led_d;
    end
  end

  assign read_data = rdata_q;
  assign mem_ready = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign led       = led_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT_CYCLES 0, 1, 3) share one
// stimulus stream and are each compared cycle by cycle with a reference model.
module tb_mem_responder;

  localparam logic [1:0] CNONE = 2'b00, CREAD = 2'b01, CWRITE = 2'b10, CILL = 2'b11;
  localparam int KMAX = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [7:0]  sw;
  logic [15:0] rd  [3];
  logic        rdy [3];
  logic        bsy [3];
  logic [7:0]  led [3];

  int errors = 0;
  int checks = 0;

  logic [15:0] mm      [3][256];
  logic [15:0] rd_exp  [3];
  logic [7:0]  led_exp [3];

  always #5 clk = ~clk;

  mem_responder #(.WAIT_CYCLES(0)) u_wc0 (
    .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .write_data(write_data), .read_data(rd[0]), .mem_ready(rdy[0]),
    .busy(bsy[0]), .sw(sw), .led(led[0]));
  mem_responder #(.WAIT_CYCLES(1)) u_wc1 (
    .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .write_data(write_data), .read_data(rd[1]), .mem_ready(rdy[1]),
    .busy(bsy[1]), .sw(sw), .led(led[1]));
  mem_responder #(.WAIT_CYCLES(3)) u_wc3 (
    .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .write_data(write_data), .read_data(rd[2]), .mem_ready(rdy[2]),
    .busy(bsy[2]), .sw(sw), .led(led[2]));

  function automatic int wc(input int i);
    case (i)
      0: return 0;
      1: return 1;
      default: return 3;
    endcase
  endfunction

  function automatic logic [15:0] model_read(input int i, input logic [8:0] a);
`ifdef MEM_MMIO_EN
    if (a == 9'h140) return {8'h00, sw};
`endif
    if (a < 9'd256) return mm[i][a[7:0]];
    return 16'h0000;
  endfunction

  // Present one command (held for 'hold' accept edges), optionally pulse reset
  // in cycle reset_at, and compare every instance for KMAX cycles.
  // An instance with W wait states accepts at edges 0, W+2, 2(W+2)... while the
  // command is held, and completes in cycle accept+W+1.
  task automatic exercise(input logic [1:0] cmd, input logic [8:0] addr,
                          input logic [15:0] data, input int hold,
                          input int reset_at, input string tag);
    bit legal = (cmd == CREAD) || (cmd == CWRITE);
    @(negedge clk);
    mem_cmd = cmd; mem_addr = addr; write_data = data;
    for (int k = 1; k <= KMAX; k++) begin
      @(negedge clk);
      if (k == hold) mem_cmd = CNONE;
      if (reset_at > 0 && k == reset_at + 1)
        for (int i = 0; i < 3; i++) begin rd_exp[i] = '0; led_exp[i] = '0; end
      for (int i = 0; i < 3; i++) begin
        int  w = wc(i);
        bit  aborted = (reset_at > 0) && (k > reset_at);
        bit  e_rdy = 1'b0;
        bit  e_bsy = 1'b0;
        for (int a = 0; a < hold; a++) begin
          if (legal && (a % (w + 2)) == 0 && (reset_at == 0 || a < reset_at) && !aborted) begin
            if (k == a + w + 1) e_rdy = 1'b1;
            if (k > a && k <= a + w + 1) e_bsy = 1'b1;
          end
        end
        if (e_rdy && cmd == CREAD) rd_exp[i] = model_read(i, addr);
        checks++;
        if (rdy[i] !== e_rdy) begin
          errors++;
          $display("FAIL %s ready dut%0d cyc%0d got %b want %b", tag, i, k, rdy[i], e_rdy);
        end
        checks++;
        if (bsy[i] !== e_bsy) begin
          errors++;
          $display("FAIL %s busy dut%0d cyc%0d got %b want %b", tag, i, k, bsy[i], e_bsy);
        end
        checks++;
        if (rd[i] !== rd_exp[i]) begin
          errors++;
          $display("FAIL %s read_data dut%0d cyc%0d got %h want %h", tag, i, k, rd[i], rd_exp[i]);
        end
        checks++;
        if (led[i] !== led_exp[i]) begin
          errors++;
          $display("FAIL %s led dut%0d cyc%0d got %h want %h", tag, i, k, led[i], led_exp[i]);
        end
        // Writes take effect at the end of the completion cycle unless reset hits it
        if (e_rdy && cmd == CWRITE && !(reset_at > 0 && k == reset_at)) begin
`ifdef MEM_MMIO_EN
          if (addr == 9'h100) led_exp[i] = data[7:0];
          else
`endif
          if (addr < 9'd256) mm[i][addr[7:0]] = data;
        end
      end
      reset = (reset_at > 0 && k == reset_at);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_cmd = CNONE; mem_addr = '0; write_data = '0; sw = 8'h5A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rdy[i] !== 1'b0 || bsy[i] !== 1'b0 || rd[i] !== 16'h0 || led[i] !== 8'h0) begin
        errors++;
        $display("FAIL reset dut%0d got rdy=%b busy=%b rd=%h led=%h want 0 0 0000 00",
                 i, rdy[i], bsy[i], rd[i], led[i]);
      end
      rd_exp[i] = '0; led_exp[i] = '0;
    end
    reset = 1'b0;
  endtask

  task automatic test_preload();
    for (int a = 0; a < 32; a++) exercise(CWRITE, 9'(a), 16'($urandom), 1, 0, "preload");
  endtask

  task automatic test_write_read();
    exercise(CWRITE, 9'd5, 16'h1234, 1, 0, "wr5");
    exercise(CREAD,  9'd5, 16'h0,    1, 0, "rd5");
    checks++;
    if (rd[1] !== 16'h1234) begin
      errors++; $display("FAIL write_read got %h want 1234", rd[1]);
    end
  endtask

  task automatic test_latency();
    exercise(CREAD, 9'd0, 16'h0, 1, 0, "lat_rd0");
  endtask

  task automatic test_out_of_range();
    exercise(CWRITE, 9'h0F0, 16'h7777, 1, 0, "oor_pre");
    exercise(CWRITE, 9'h1F0, 16'hBEEF, 1, 0, "oor_wr");
    exercise(CREAD,  9'h1F0, 16'h0,    1, 0, "oor_rd");
    checks++;
    if (rd[1] !== 16'h0000) begin
      errors++; $display("FAIL oor_read got %h want 0000", rd[1]);
    end
    exercise(CREAD, 9'h0F0, 16'h0, 1, 0, "oor_alias");
    checks++;
    if (rd[1] !== 16'h7777) begin
      errors++; $display("FAIL oor_alias got %h want 7777", rd[1]);
    end
  endtask

  task automatic test_reset_abort();
    exercise(CWRITE, 9'd7, 16'h0000, 1, 0, "abort_pre");
    exercise(CWRITE, 9'd7, 16'hAAAA, 1, 1, "abort1");
    exercise(CREAD,  9'd7, 16'h0,    1, 0, "abort1_rd");
    checks++;
    if (rd[1] !== 16'h0000) begin
      errors++; $display("FAIL abort_read got %h want 0000", rd[1]);
    end
    // Reset in cycle 2: the zero-wait instance already completed, the others abort
    exercise(CWRITE, 9'd7, 16'h5555, 1, 2, "abort2");
    exercise(CREAD,  9'd7, 16'h0,    1, 0, "abort2_rd");
    checks++;
    if (rd[0] !== 16'h5555 || rd[2] !== 16'h0000) begin
      errors++; $display("FAIL abort2_read got %h/%h want 5555/0000", rd[0], rd[2]);
    end
  endtask

  task automatic test_illegal_held();
    exercise(CILL,  9'd3, 16'hFFFF, 5, 0, "illegal");
    exercise(CREAD, 9'd5, 16'h0,    4, 0, "held_rd");
  endtask

  task automatic test_mmio();
    sw = 8'h5A;
    exercise(CWRITE, 9'h100, 16'h00C3, 1, 0, "mmio_led");
    exercise(CREAD,  9'h140, 16'h0,    1, 0, "mmio_sw");
    checks++;
`ifdef MEM_MMIO_EN
    if (led[1] !== 8'hC3 || rd[1] !== 16'h005A) begin
      errors++; $display("FAIL mmio got led=%h rd=%h want C3 005A", led[1], rd[1]);
    end
`else
    if (led[1] !== 8'h00 || rd[1] !== 16'h0000) begin
      errors++; $display("FAIL mmio got led=%h rd=%h want 00 0000", led[1], rd[1]);
    end
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int          r = int'($urandom_range(0, 9));
      logic [8:0]  a;
      logic [1:0]  c = 2'($urandom_range(0, 3));
      if (r < 7)       a = 9'($urandom_range(0, 31));
      else if (r == 7) a = 9'h100;
      else if (r == 8) a = 9'h140;
      else             a = 9'($urandom_range(256, 511));
      sw = 8'($urandom);
      exercise(c, a, 16'($urandom), int'($urandom_range(1, 3)),
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_write_read();
    test_latency();
    test_out_of_range();
    test_reset_abort();
    test_illegal_held();
    test_mmio();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU controller's mem_cmd bus (MNONE/MREAD/MWRITE). It accepts one command at a time and inserts a programmable number of wait states.
- Each access completes against an internal word RAM and is acknowledged with a one-cycle mem_ready pulse.
- It sits between the CPU datapath (address register / datapath_out) and storage, with optional switch/LED memory-mapped I/O.

Parameters:
- AW, 9, address width in bits.
- DW, 16, data word width.
- DEPTH, 256, number of RAM words; valid RAM addresses are 0..DEPTH-1.
- WAIT_CYCLES, 1, wait states between command acceptance and completion; legal range 0..15.
- LED_ADDR, 9'h100, MMIO write address for the LEDs.
- SW_ADDR, 9'h140, MMIO read address for the switches.

Ports:
- clk  input  1  rising-edge clock; one clock domain.
- reset  input  1  synchronous, active-high reset.
- mem_cmd  input  2  00=MNONE, 01=MREAD, 10=MWRITE, 11=illegal.
- mem_addr  input  AW  word address.
- write_data  input  DW  store data.
- read_data  output  DW  load data; registered.
- mem_ready  output  1  completion pulse, one cycle.
- busy  output  1  high whenever state != IDLE.
- sw  input  8  switch inputs (MMIO).
- led  output  8  LED register (MMIO).

Behaviour:
- Reset values: state=IDLE, read_data=0, mem_ready=0, busy=0, led=0, wait counter=0. RAM contents are not reset.
- States: IDLE, WAIT, DONE.
- IDLE:
  - Samples mem_cmd every edge.
  - MREAD or MWRITE: latch cmd, addr and write_data; counter=WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise DONE.
  - MNONE or 11: stay in IDLE; 11 has no side effects.
- WAIT:
  - Counter decrements each edge; moves to DONE on the edge where counter==1.
  - Bus inputs are ignored; only latched values are used.
- DONE:
  - Lasts exactly one cycle; mem_ready=1 for that cycle.
  - Reads: read_data holds the latched-address data in this cycle.
  - Writes: the RAM word is written on the edge leaving DONE.
  - Always returns to IDLE.
- Latency: command present at edge N gives mem_ready high in the cycle after edge N+WAIT_CYCLES.
  - WAIT_CYCLES=0 means ready in the cycle after the accept edge.
- read_data is held until the next read completes; writes do not alter it.
- Back-to-back rule: no command is accepted during WAIT or DONE. If mem_cmd is still non-MNONE in the first IDLE cycle after DONE, it is treated as a new request.
- Out-of-range address (>= DEPTH and not an enabled MMIO address):
  - Read returns 0.
  - Write is discarded.
  - mem_ready still pulses with normal latency.
- Read-after-write to the same address, issued in the IDLE cycle following the write's DONE, returns the new data.
- Reset in WAIT or DONE: abort immediately; no RAM or LED write occurs; all outputs take their reset values on that edge.
- Address width: only mem_addr[AW-1:0] is used; no wrap-around. Addresses >= DEPTH are out-of-range, not aliased.

Optional Feature:
- Macro: MEM_MMIO_EN.
- Defined:
  - A write to LED_ADDR loads led <= write_data[7:0] on the edge leaving DONE.
  - A read of SW_ADDR returns {8'b0, sw} as sampled in DONE.
  - Both addresses take priority over RAM decode.
- Undefined:
  - led is tied to 0 and sw is unused.
  - LED_ADDR and SW_ADDR follow the out-of-range rules.

Decomposition:
- Package mem_pkg:
  - MNONE/MREAD/MWRITE 2-bit constants, shared with the CPU controller.
  - State enum type (IDLE/WAIT/DONE).
  - Default LED_ADDR/SW_ADDR constants.
- Sub-module ram_array: single-port, synchronous write, combinational read, DEPTH x DW.
- mem_responder contains the FSM, command latches, address decode, MMIO and the read_data register.

Test Plan:
- Write, then read, WAIT_CYCLES=1: MWRITE addr 5 data 16'h1234, then MREAD addr 5 → mem_ready rises 2 cycles after each accept; read_data=16'h1234.
- Latency sweep WAIT_CYCLES=0 and 3: MREAD addr 0 → mem_ready exactly 1 and 4 cycles after accept, each one cycle wide; busy high throughout.
- Out-of-range: MWRITE addr 9'h1F0 data 16'hBEEF, then MREAD 9'h1F0 → read_data=0; mem_ready pulses; RAM word 0x0F0 unchanged.
- Reset abort: MWRITE addr 7 data 16'hAAAA; assert reset during WAIT → mem_ready never pulses; a later MREAD addr 7 returns the prior value 16'h0000.
- Illegal and held command: mem_cmd=11 for 5 cycles → no mem_ready, busy=0. MREAD held high across DONE → two mem_ready pulses.
- With MEM_MMIO_EN, sw=8'h5A: MWRITE LED_ADDR data 16'h00C3 → led=8'hC3; MREAD SW_ADDR → read_data=16'h005A. Without the macro → led stays 0 and the read returns 0.
